// File: rtl/mt_pkg.sv
// Shared MT19937 constants, generation FSM encoding and twist helper used by
// mt_mem, the generation stage and the top level.
package mt_pkg;

  localparam int unsigned MT_N = 624;
  localparam int unsigned MT_M = 397;

  localparam logic [31:0] MATRIX_A   = 32'h9908_B0DF;
  localparam logic [31:0] UPPER_MASK = 32'h8000_0000;
  localparam logic [31:0] LOWER_MASK = 32'h7FFF_FFFF;
  localparam logic [31:0] TEMPER_B   = 32'h9D2C_5680;
  localparam logic [31:0] TEMPER_C   = 32'hEFC6_0000;

  typedef enum logic {
    RUN    = 1'b0,
    COMMIT = 1'b1
  } mt_gen_state_t;

  function automatic logic [31:0] mt_twist(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] c);
    logic [31:0] y;
    y = (a & UPPER_MASK) | (b & LOWER_MASK);
    return c ^ (y >> 1) ^ (y[0] ? MATRIX_A : '0);
  endfunction

endpackage

// File: rtl/mt_temper.sv
// MT19937 output tempering: purely combinational 32-bit to 32-bit transform.
module mt_temper
  import mt_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  logic [31:0] t1;
  logic [31:0] t2;
  logic [31:0] t3;

  always_comb begin
    t1   = din ^ (din >> 11);
    t2   = t1 ^ ((t1 << 7) & TEMPER_B);
    t3   = t2 ^ ((t2 << 15) & TEMPER_C);
    dout = t3 ^ (t3 >> 18);
  end

endmodule

// File: rtl/mt_twist_temper.sv
// MT19937 generation stage: twists the current state word by word into a
// next-state buffer, streams tempered words out, then commits the buffer.
module mt_twist_temper
  import mt_pkg::*;
#(
  parameter int unsigned N = MT_N,
  parameter int unsigned M = MT_M
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                gen_en,
  input  logic [N-1:0][31:0]  state_cur,
  output logic [N-1:0][31:0]  state_next,
  output logic                state_we,
  output logic [31:0]         rnd_data,
  output logic                rnd_valid,
  input  logic                rnd_ready
);

  localparam int unsigned IW = $clog2(N);
  localparam logic [IW-1:0] LAST  = IW'(N - 1);
  localparam logic [IW-1:0] SPLIT = IW'(N - M);
  localparam logic [IW-1:0] OFF_M = IW'(M);

  mt_gen_state_t      state_q, state_d;
  logic [IW-1:0]      i_q, i_d;
  logic [N-1:0][31:0] state_next_q, state_next_d;
  logic [31:0]        rnd_data_q, rnd_data_d;
  logic               rnd_valid_q, rnd_valid_d;
  logic               state_we_q, state_we_d;

  logic [IW-1:0]      idx_b, idx_c;
  logic [31:0]        op_a, op_b, op_c;
  logic [31:0]        word_new, word_tempered;
  logic               advance;

  // Operands past the wrap point come from words already rewritten this block.
  always_comb begin
    idx_b    = i_q + IW'(1);
    idx_c    = (i_q < SPLIT) ? (i_q + OFF_M) : (i_q - SPLIT);
    op_a     = state_cur[i_q];
    op_b     = (i_q == LAST) ? state_next_q[0] : state_cur[idx_b];
    op_c     = (i_q < SPLIT) ? state_cur[idx_c] : state_next_q[idx_c];
    word_new = mt_twist(op_a, op_b, op_c);
  end

  mt_temper u_temper (
    .din  (word_new),
    .dout (word_tempered)
  );

  always_comb begin
    advance      = (state_q == RUN) && gen_en && (!rnd_valid_q || rnd_ready);
    state_d      = state_q;
    i_d          = i_q;
    state_next_d = state_next_q;
    rnd_data_d   = rnd_data_q;
    rnd_valid_d  = rnd_valid_q && !rnd_ready;
    state_we_d   = 1'b0;

    unique case (state_q)
      RUN: begin
        if (advance) begin
          state_next_d[i_q] = word_new;
          rnd_data_d        = word_tempered;
          rnd_valid_d       = 1'b1;
          if (i_q == LAST) begin
            i_d        = '0;
            state_d    = COMMIT;
            state_we_d = 1'b1;
          end else begin
            i_d = i_q + IW'(1);
          end
        end
      end
      COMMIT: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      i_q          <= '0;
      state_next_q <= '0;
      rnd_data_q   <= '0;
      rnd_valid_q  <= 1'b0;
      state_we_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      state_next_q <= state_next_d;
      rnd_data_q   <= rnd_data_d;
      rnd_valid_q  <= rnd_valid_d;
      state_we_q   <= state_we_d;
    end
  end

  assign state_next = state_next_q;
  assign state_we   = state_we_q;
  assign rnd_data   = rnd_data_q;
  assign rnd_valid  = rnd_valid_q;

endmodule
